regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREG, default 32: register count; power of two, >= 4; AW = log2(NREG) is derived and is not a parameter.
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 RA1, RA2  input  AW  read addresses.
REQ-007 RD1, RD2  output  XLEN  read data, combinational from address.
REQ-008 WE3  input  1  writeback enable.
REQ-009 WA3  input  AW  writeback address.
REQ-010 WD3  input  XLEN  writeback data.
REQ-011 ISSUE_EN  input  1  marks an instruction issue with a pending destination.
REQ-012 ISSUE_RD  input  AW  destination register of the issued instruction.
REQ-013 BUSY1, BUSY2  output  1  the register at RA1 / RA2 has a pending, unwritten result.
REQ-014 READY  output  1  registered; high once the initial clear has finished.

Function
REQ-015 The FSM SHALL have two states: CLEAR and RUN.
REQ-016 CLEAR SHALL write 0 to entry CNT and increment the AW-bit counter CNT once per cycle.
REQ-017 CLEAR SHALL go to RUN on the edge that clears entry NREG-1, so CLEAR lasts exactly NREG cycles after rst_n rises.
REQ-018 READY SHALL be 0 in CLEAR and 1 in RUN.
REQ-019 In CLEAR, WE3 and ISSUE_EN SHALL be ignored; RD1, RD2, BUSY1 and BUSY2 SHALL read 0.
REQ-020 In RUN, a rising edge with WE3=1 and WA3!=0 SHALL store WD3 into entry WA3.
REQ-021 A write with WA3=0 SHALL be discarded; entry 0 always reads 0.
REQ-022 RDn SHALL be 0 when RAn=0.
REQ-023 Else, with BYPASS=1, WE3=1 and WA3=RAn, RDn SHALL be WD3 in the same cycle.
REQ-024 Otherwise RDn SHALL be the stored entry RAn.
REQ-025 A busy vector of NREG bits SHALL be kept; bit 0 is constant 0.
REQ-026 In RUN, ISSUE_EN=1 with ISSUE_RD!=0 SHALL set busy[ISSUE_RD] at the edge.
REQ-027 In RUN, WE3=1 with WA3!=0 SHALL clear busy[WA3] at the edge.
REQ-028 When a set and a clear target the same register in the same cycle, the set SHALL win, because a newer producer has been issued.
REQ-029 A set and a clear to different registers in the same cycle SHALL both take effect.
REQ-030 BUSYn SHALL be busy[RAn], except that with BYPASS=1, WE3=1, WA3=RAn and RAn!=0 it SHALL be 0.
REQ-031 With BYPASS=0, BUSYn SHALL be busy[RAn] unmodified; the consumer waits one cycle.
REQ-032 Issuing to a register that is already busy SHALL leave it busy; there is no error flag.
REQ-033 Writing a register that is not busy SHALL update the data and leave busy at 0.
REQ-034 Both read ports SHALL be fully independent; RA1=RA2 is legal and gives identical outputs.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force CLEAR, CNT=0, busy=all 0 and READY=0.
REQ-036 While rst_n=0 the block SHALL hold that state; clearing starts on the first edge with rst_n=1.
REQ-037 rst_n=0 asserted mid-CLEAR or mid-RUN SHALL restart the sweep from entry 0.
REQ-038 Any pending writeback or issue in the reset cycle SHALL be dropped.

Verification
REQ-039 Init clear (NREG=32): release rst_n -> READY=0 for 32 cycles, then 1; all RAn then read 0 and BUSYn=0.
REQ-040 Write/read: WE3=1, WA3=5, WD3=0xDEADBEEF, RA1=5, BYPASS=1 -> RD1=0xDEADBEEF in that cycle and still after the edge; same with BYPASS=0 -> RD1=0 in that cycle, 0xDEADBEEF next cycle.
REQ-041 Register 0: WE3=1, WA3=0, WD3=0x1234 and ISSUE_EN=1, ISSUE_RD=0 -> RD1=0 and BUSY1=0 for RA1=0, in that cycle and after.
REQ-042 Scoreboard: issue rd=7 -> BUSY2=1 for RA2=7; writeback WA3=7 -> BUSY2=0 that cycle with BYPASS=1, or next cycle with BYPASS=0.
REQ-043 Same-cycle collision: busy[9]=1, then ISSUE_RD=9 and WA3=9 with WE3=1 in one cycle -> data updated, busy[9] stays 1.
REQ-044 Reset mid-run: registers 3 and 4 written and busy[3]=1, pulse rst_n low for 1 cycle -> READY=0 for 32 cycles, then RD=0 and BUSY=0 for 3 and 4; WE3 during CLEAR has no effect.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// This block is a register file with two read ports and one write port. It also
// tracks which registers have a result still pending (a scoreboard).
//
// After reset, a sweep writes zero into every entry, one entry per cycle. The
// block then enters normal operation.
//
// Each register has a busy bit:
//   - An issued instruction sets the busy bit of its destination register.
//   - A writeback clears it.
//   - If a set and a clear target the same register in the same cycle, the set
//     wins, because a newer producer has been issued.
//
// With BYPASS != 0, a writeback is forwarded to the read ports in the same cycle
// as the write. The forwarded write also shows the register as not busy.
//
// Parameters
//   XLEN    data width in bits
//   NREG    register count (power of two, >= 4)
//   BYPASS  1: forward write data to the read ports in the same cycle; 0: no
//           forwarding
//
// Ports
//   clk                sole clock, rising edge
//   rst_n              synchronous active-low reset
//   RA1, RA2           read addresses
//   RD1, RD2           read data, combinational from address
//   WE3, WA3, WD3      writeback enable / address / data
//   ISSUE_EN, ISSUE_RD issue strobe and destination register
//   BUSY1, BUSY2       the register at RA1 / RA2 has a pending result
//   READY              registered; high once the initial clear has finished
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [$clog2(NREG)-1:0]   RA1,
   input  logic [$clog2(NREG)-1:0]   RA2,
   output logic [XLEN-1:0]           RD1,
   output logic [XLEN-1:0]           RD2,
   input  logic                      WE3,
   input  logic [$clog2(NREG)-1:0]   WA3,
   input  logic [XLEN-1:0]           WD3,
   input  logic                      ISSUE_EN,
   input  logic [$clog2(NREG)-1:0]   ISSUE_RD,
   output logic                      BUSY1,
   output logic                      BUSY2,
   output logic                      READY
);

   localparam int AW = $clog2(NREG);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [AW-1:0]     r_cnt;
   logic              r_ready;
   logic              w_clr_we;

   logic [XLEN-1:0]   r_mem [NREG];
   logic [NREG-1:0]   r_busy;
   logic [NREG-1:0]   w_busy_next;

   logic              w_run;
   logic              w_wr;       // architectural write: RUN, enabled, not x0
   logic              w_iss;      // architectural issue: RUN, enabled, not x0
   logic              w_fwd1;
   logic              w_fwd2;

   assign w_run = (r_state == S_RUN);
   assign w_wr  = w_run && WE3 && (WA3 != '0);
   assign w_iss = w_run && ISSUE_EN && (ISSUE_RD != '0);

   // ---------------------------------------------------------------------------
   // Control FSM: CLEAR sweeps entries 0..NREG-1, then RUN.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the values from before the edge, whatever the order of the blocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state == S_RUN);
         if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // NOTE: every signal driven here gets a default first. A signal left
   // unassigned on some path would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_clr_we     = 1'b0;
      unique case (r_state)
         S_CLEAR: begin
            w_clr_we = 1'b1;
            // The counter reaching all-ones means this edge clears the last entry.
            if (r_cnt == {AW{1'b1}}) begin
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            w_next_state = S_RUN;
         end
         default: begin
            w_next_state = S_CLEAR;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Storage array
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset branch. This keeps it mappable to RAM. The
   // clear sweep zeroes it instead, and the read ports are gated to 0 until the
   // sweep is done.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr) begin
            r_mem[WA3] <= WD3;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard. The set is applied after the clear, so that it wins a collision
   // on the same register.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_busy_next = r_busy;
      if (w_wr) begin
         w_busy_next[WA3] = 1'b0;
      end
      if (w_iss) begin
         w_busy_next[ISSUE_RD] = 1'b1;
      end
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports. These are combinational and forced to 0 during CLEAR and for
   // address 0. Forwarding depends only on the write strobe and the address.
   // ---------------------------------------------------------------------------
   assign w_fwd1 = (BYPASS != 0) && WE3 && (WA3 == RA1);
   assign w_fwd2 = (BYPASS != 0) && WE3 && (WA3 == RA2);

   always_comb begin
      RD1   = '0;
      BUSY1 = 1'b0;
      if (w_run && (RA1 != '0)) begin
         if (w_fwd1) begin
            RD1   = WD3;
            BUSY1 = 1'b0;
         end else begin
            RD1   = r_mem[RA1];
            BUSY1 = r_busy[RA1];
         end
      end
   end

   always_comb begin
      RD2   = '0;
      BUSY2 = 1'b0;
      if (w_run && (RA2 != '0)) begin
         if (w_fwd2) begin
            RD2   = WD3;
            BUSY2 = 1'b0;
         end else begin
            RD2   = r_mem[RA2];
            BUSY2 = r_busy[RA2];
         end
      end
   end

   assign READY = r_ready;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Self-checking bench. Two copies of regfile_scoreboard are driven with the same
// stimulus: one with forwarding (BYPASS=1) and one without (BYPASS=0).
//
// A behavioural model holds:
//   - a plain data array,
//   - a busy array,
//   - a ready flag and a sweep position.
//
// Every cycle, the model's expected outputs for both copies are compared with
// the DUT outputs. The comparison happens 1 ns after the falling edge, with the
// inputs already applied.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   ra1, ra2, wa, ird;
   logic [XLEN-1:0] wd;
   logic            we, iss;

   logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic            busy1_b, busy2_b, busy1_n, busy2_n;
   logic            ready_b, ready_n;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_dut_byp (
      .clk(clk), .rst_n(rst_n),
      .RA1(ra1), .RA2(ra2), .RD1(rd1_b), .RD2(rd2_b),
      .WE3(we), .WA3(wa), .WD3(wd),
      .ISSUE_EN(iss), .ISSUE_RD(ird),
      .BUSY1(busy1_b), .BUSY2(busy2_b), .READY(ready_b)
   );

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_dut_nobyp (
      .clk(clk), .rst_n(rst_n),
      .RA1(ra1), .RA2(ra2), .RD1(rd1_n), .RD2(rd2_n),
      .WE3(we), .WA3(wa), .WD3(wd),
      .ISSUE_EN(iss), .ISSUE_RD(ird),
      .BUSY1(busy1_n), .BUSY2(busy2_n), .READY(ready_n)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] m_mem  [NREG];
   bit              m_busy [NREG];
   bit              m_ready;
   int              m_pos;

   // Applies the effect of one rising edge to the model, from the inputs that
   // were present at that edge.
   task automatic model_edge();
      if (!rst_n) begin
         m_ready = 0;
         m_pos   = 0;
         for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      end else if (!m_ready) begin
         m_mem[m_pos] = '0;
         if (m_pos == NREG - 1) m_ready = 1;
         m_pos = (m_pos + 1) % NREG;
      end else begin
         if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 0;
         end
         if (iss && ird != 0) m_busy[ird] = 1;
      end
   endtask

   function automatic logic [XLEN-1:0] exp_rd(input bit byp, input logic [AW-1:0] ra);
      if (!m_ready || ra == 0) return '0;
      if (byp && we && wa == ra) return wd;
      return m_mem[ra];
   endfunction

   function automatic logic exp_busy(input bit byp, input logic [AW-1:0] ra);
      if (!m_ready || ra == 0) return 1'b0;
      if (byp && we && wa == ra) return 1'b0;
      return m_busy[ra];
   endfunction

   task automatic check(input string tag, input logic [XLEN-1:0] got,
                        input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic compare_all();
      check("ready_b", 32'(ready_b),  32'(m_ready));
      check("ready_n", 32'(ready_n),  32'(m_ready));
      check("rd1_b",   rd1_b,         exp_rd(1, ra1));
      check("rd2_b",   rd2_b,         exp_rd(1, ra2));
      check("rd1_n",   rd1_n,         exp_rd(0, ra1));
      check("rd2_n",   rd2_n,         exp_rd(0, ra2));
      check("busy1_b", 32'(busy1_b),  32'(exp_busy(1, ra1)));
      check("busy2_b", 32'(busy2_b),  32'(exp_busy(1, ra2)));
      check("busy1_n", 32'(busy1_n),  32'(exp_busy(0, ra1)));
      check("busy2_n", 32'(busy2_n),  32'(exp_busy(0, ra2)));
   endtask

   // The inputs are already applied (just after the falling edge). This task
   // compares the outputs, takes the rising edge, and returns at the next
   // falling edge.
   task automatic cycle();
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      we  = 1'b0;
      iss = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 0;
      end
      m_ready = 0;
      m_pos   = 0;
      rst_n = 1'b0;
      ra1 = '0; ra2 = '0; wa = '0; ird = '0; wd = '0;
      idle();

      // The first reset edge brings the DUT out of X. Nothing is compared before it.
      @(posedge clk);
      model_edge();
      @(negedge clk);
      repeat (3) cycle();

      // Initial clear: READY stays low for NREG cycles after rst_n rises.
      rst_n = 1'b1;
      we = 1'b1; wa = 5'd6; wd = 32'h5555_5555; iss = 1'b1; ird = 5'd6;
      for (int i = 0; i < NREG; i++) begin
         #1 check("clr_ready_low", 32'(ready_b), 32'd0);
         cycle();
      end
      idle();
      #1 check("clr_ready_high", 32'(ready_b), 32'd1);
      for (int i = 0; i < NREG; i++) begin
         ra1 = AW'(i); ra2 = AW'(NREG - 1 - i);
         #1 check("clr_zero", rd1_b | rd2_b | rd1_n | rd2_n, 32'd0);
         check("clr_nobusy", 32'({busy1_b, busy2_b, busy1_n, busy2_n}), 32'd0);
         cycle();
      end

      // Write and read back, with and without forwarding.
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5;
      #1 check("wr_byp_same",   rd1_b, 32'hDEAD_BEEF);
      check("wr_nobyp_same", rd1_n, 32'h0);
      cycle();
      idle();
      #1 check("wr_byp_next",   rd1_b, 32'hDEAD_BEEF);
      check("wr_nobyp_next", rd1_n, 32'hDEAD_BEEF);
      cycle();

      // Register 0 is never written and never busy.
      we = 1'b1; wa = 5'd0; wd = 32'h1234; iss = 1'b1; ird = 5'd0; ra1 = 5'd0;
      #1 check("x0_rd_same",   rd1_b, 32'h0);
      check("x0_busy_same", 32'(busy1_b), 32'd0);
      cycle();
      idle();
      #1 check("x0_rd_next",   rd1_b | rd1_n, 32'h0);
      check("x0_busy_next", 32'(busy1_b | busy1_n), 32'd0);
      cycle();

      // Scoreboard set, then clear by writeback.
      iss = 1'b1; ird = 5'd7; ra2 = 5'd7;
      cycle();
      idle();
      #1 check("sb_busy_set_b", 32'(busy2_b), 32'd1);
      check("sb_busy_set_n", 32'(busy2_n), 32'd1);
      we = 1'b1; wa = 5'd7; wd = 32'h0000_0777;
      #1 check("sb_wb_byp",   32'(busy2_b), 32'd0);
      check("sb_wb_nobyp", 32'(busy2_n), 32'd1);
      cycle();
      idle();
      #1 check("sb_wb_nobyp_next", 32'(busy2_n), 32'd0);
      cycle();

      // Same-cycle set and clear on register 9: the set wins and the data updates.
      iss = 1'b1; ird = 5'd9;
      cycle();
      iss = 1'b1; ird = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'hCAFE_0009;
      cycle();
      idle(); ra1 = 5'd9;
      #1 check("coll_busy", 32'(busy1_b & busy1_n), 32'd1);
      check("coll_data", rd1_n, 32'hCAFE_0009);
      cycle();

      // Reset in the middle of RUN: data and busy state are wiped, and a write
      // during CLEAR is ignored.
      we = 1'b1; wa = 5'd3; wd = 32'h0000_0033;
      cycle();
      we = 1'b1; wa = 5'd4; wd = 32'h0000_0044; iss = 1'b1; ird = 5'd3;
      cycle();
      idle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF;
      for (int i = 0; i < NREG; i++) begin
         #1 check("mid_ready_low", 32'(ready_b | ready_n), 32'd0);
         cycle();
      end
      idle(); ra1 = 5'd3; ra2 = 5'd4;
      #1 check("mid_ready",  32'(ready_b), 32'd1);
      check("mid_rd3",    rd1_b, 32'h0);
      check("mid_rd4",    rd2_n, 32'h0);
      check("mid_busy3",  32'(busy1_b | busy1_n), 32'd0);
      cycle();

      // Randomized traffic with occasional resets. Addresses are biased to a
      // small range so that collisions happen often.
      for (int n = 0; n < 4000; n++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         we    = 1'($urandom_range(0, 1));
         iss   = 1'($urandom_range(0, 1));
         wd    = $urandom;
         wa    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         ird   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         ra1   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         ra2   = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
